// File: rtl/sync_toggle_rx_pkg.sv
// Shared definitions for the toggle-handshake receiver: FSM state encoding
// and default payload/counter widths.
package sync_toggle_rx_pkg;

    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_e;

endpackage : sync_toggle_rx_pkg

// File: rtl/sync_toggle_rx_if.sv
// Local-domain valid/ready output channel of sync_toggle_rx.
//   dout_pvld  captured payload valid  (master -> slave)
//   dout_prdy  consumer ready          (slave  -> master)
//   dout_pd    captured payload        (master -> slave)
interface sync_toggle_rx_if
    import sync_toggle_rx_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) ();

    logic          dout_pvld;
    logic          dout_prdy;
    logic [DW-1:0] dout_pd;

    modport master (
        output dout_pvld,
        output dout_pd,
        input  dout_prdy
    );

    modport slave (
        input  dout_pvld,
        input  dout_pd,
        output dout_prdy
    );

endinterface : sync_toggle_rx_if

// File: rtl/sync_toggle_rx.sv
// Receive side of a toggle-based clock-domain-crossing handshake.
// Detects each edge of the already-synchronized request toggle, captures the
// quasi-static source payload, offers it on a valid/ready channel and returns
// an acknowledge toggle once the local consumer accepts it.
// Ports:
//   clk           core clock
//   clr_          synchronous active-low reset
//   req_tog_sync  request toggle, synchronized into clk
//   req_data      source payload, stable while the request is outstanding
//   ack_tog       acknowledge toggle back to the source domain (flop output)
//   dout          valid/ready payload channel (master side)
//   overrun       sticky: request edge seen while a payload was still pending
//   xfer_cnt      number of accepted transfers, wraps
module sync_toggle_rx
    import sync_toggle_rx_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                clr_,
    input  logic                req_tog_sync,
    input  logic [DW-1:0]       req_data,
    output logic                ack_tog,
    sync_toggle_rx_if.master    dout,
    output logic                overrun,
    output logic [CNT_W-1:0]    xfer_cnt
);

    state_e             state_q, state_d;
    logic               tog_q, tog_d;
    logic               ack_q, ack_d;
    logic [DW-1:0]      pd_q, pd_d;
    logic               ovr_q, ovr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_edge_c;

    // tog_q holds the last toggle level taken in, so any difference is a new request
    assign req_edge_c = req_tog_sync ^ tog_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!clr_) begin
            state_q <= ST_IDLE;
            tog_q   <= 1'b0;
            ack_q   <= 1'b0;
            pd_q    <= '0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tog_q   <= tog_d;
            ack_q   <= ack_d;
            pd_q    <= pd_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        tog_d   = tog_q;
        ack_d   = ack_q;
        pd_d    = pd_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_edge_c) begin
                    pd_d    = req_data;
                    tog_d   = req_tog_sync;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // An edge while busy is absorbed and flagged; the pending payload is untouched
                if (req_edge_c) begin
                    ovr_d = 1'b1;
                    tog_d = req_tog_sync;
                end
                if (dout.dout_prdy) begin
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // VALID is encoded as 1, so the state flop directly drives valid
    assign dout.dout_pvld = (state_q == ST_VALID);
    assign dout.dout_pd   = pd_q;
    assign ack_tog        = ack_q;
    assign overrun        = ovr_q;
    assign xfer_cnt       = cnt_q;

endmodule : sync_toggle_rx

// File: tb/tb_sync_toggle_rx.sv
// Scoreboard bench for sync_toggle_rx: the stimulus process queues each
// expected payload as it raises a request; the monitor checks every output
// cycle against the queue head and a small ack/count/overrun model.
module tb_sync_toggle_rx;

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             clr_;
    logic             req_tog_sync;
    logic [DW-1:0]    req_data;
    logic             ack_tog;
    logic             overrun;
    logic [CNT_W-1:0] xfer_cnt;

    sync_toggle_rx_if #(.DW(DW)) dout_if ();

    sync_toggle_rx #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .clr_         (clr_),
        .req_tog_sync (req_tog_sync),
        .req_data     (req_data),
        .ack_tog      (ack_tog),
        .dout         (dout_if.master),
        .overrun      (overrun),
        .xfer_cnt     (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_ovr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    logic             exp_ack   = 1'b0;
    logic [CNT_W-1:0] exp_cnt   = '0;
    logic             chk_after = 1'b0;
    logic             prev_rst  = 1'b0;

    always @(negedge clk) begin
        if (chk_after) begin
            chk("ack_tog", 64'(ack_tog), 64'(exp_ack));
            chk("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
            chk_after = 1'b0;
        end
        if (prev_rst) begin
            chk("rst_pvld", 64'(dout_if.dout_pvld), 64'(0));
            chk("rst_ack", 64'(ack_tog), 64'(0));
            chk("rst_cnt", 64'(xfer_cnt), 64'(0));
            chk("rst_ovr", 64'(overrun), 64'(0));
            chk("rst_pd", 64'(dout_if.dout_pd), 64'(0));
            prev_rst = 1'b0;
        end
        if (!clr_) begin
            exp_q.delete();
            exp_ack   = 1'b0;
            exp_cnt   = '0;
            chk_after = 1'b0;
            prev_rst  = 1'b1;
        end else begin
            chk("overrun", 64'(overrun), 64'(exp_ovr));
            if (dout_if.dout_pvld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pvld", 64'(dout_if.dout_pvld), 64'(0));
                end else begin
                    chk("dout_pd", 64'(dout_if.dout_pd), 64'(exp_q[0]));
                    if (dout_if.dout_prdy === 1'b1) begin
                        void'(exp_q.pop_front());
                        exp_ack   = ~exp_ack;
                        exp_cnt   = exp_cnt + CNT_W'(1);
                        chk_after = 1'b1;
                    end
                end
            end else if (dout_if.dout_pvld !== 1'b0) begin
                chk("pvld_known", 64'(dout_if.dout_pvld), 64'(0));
            end
        end
    end

    // Raise one request and wait for pvld; returns with the clock just past an edge
    task automatic raise_req(input logic [DW-1:0] d);
        bit seen;
        exp_q.push_back(d);
        req_data     = d;
        req_tog_sync = ~req_tog_sync;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (dout_if.dout_pvld === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("pvld_timeout", 64'(0), 64'(1));
    endtask

    // Hold off for 'hold' edges, then accept and wait for pvld to drop
    task automatic accept(input int hold);
        bit gone;
        repeat (hold) @(posedge clk);
        #1 dout_if.dout_prdy = 1'b1;
        gone = 1'b0;
        for (int i = 0; i < 8 && !gone; i++) begin
            @(posedge clk); #1;
            if (dout_if.dout_pvld === 1'b0) gone = 1'b1;
        end
        if (!gone) chk("accept_timeout", 64'(0), 64'(1));
        dout_if.dout_prdy = 1'b0;
    endtask

    task automatic xfer(input logic [DW-1:0] d, input int hold);
        raise_req(d);
        accept(hold);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        clr_ = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            req_tog_sync = ~req_tog_sync;
        end
        exp_ovr      = 1'b0;
        req_tog_sync = 1'b0;
        clr_         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        clr_              = 1'b0;
        req_tog_sync      = 1'b0;
        req_data          = '0;
        dout_if.dout_prdy = 1'b0;

        // Reset held 3 clocks with the toggle moving
        do_reset(3);

        // Single transfer
        xfer(32'hDEAD_BEEF, 0);

        // Backpressure for 10 clocks
        xfer(32'h1234_5678, 10);

        // Overrun: second edge while the first payload is pending
        raise_req(32'hCAFE_0001);
        req_data     = 32'hBAD0_BAD0;
        req_tog_sync = ~req_tog_sync;
        @(posedge clk); #1;
        exp_ovr = 1'b1;
        accept(3);
        repeat (6) @(posedge clk);
        #1;

        // Counter wrap: 16 transfers return to 0, the 17th gives 1
        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            xfer(32'hA500_0000 | DW'(i), i % 3);
        end

        // Reset while a payload is pending, then a normal transfer
        raise_req(32'h5555_AAAA);
        repeat (2) @(posedge clk);
        #1;
        do_reset(1);
        xfer(32'h0F0F_F0F0, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) chk("queue_drain", 64'(exp_q.size()), 64'(0));
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sync_toggle_rx
